// File: rtl/reg_seq_ctrl_pkg.sv
// Shared types and constants for the register/PC sequencer and its adder.
package reg_seq_pkg;

  localparam int DATA_W = 10;
  localparam int JUMP_DEFAULT_OFF = 16;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INCR = 3'd1,
    OP_DECR = 3'd2,
    OP_JIZR = 3'd3,
    OP_JNZR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REG  = 2'd1,
    S_PCU  = 2'd2
  } state_e;

  // Unused encodings 5-7 behave as NOP.
  function automatic op_e op_decode(input logic [2:0] code);
    case (code)
      3'd1:    op_decode = OP_INCR;
      3'd2:    op_decode = OP_DECR;
      3'd3:    op_decode = OP_JIZR;
      3'd4:    op_decode = OP_JNZR;
      default: op_decode = OP_NOP;
    endcase
  endfunction

  function automatic logic op_needs_reg(input op_e op);
    op_needs_reg = (op == OP_INCR) || (op == OP_DECR);
  endfunction

endpackage

// File: rtl/reg_seq_ctrl_arith.sv
// Shared adder: +1, -1, or +jump offset (2*v, or 16 when v is zero).
module reg_arithmetic
  import reg_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] x,
  input  logic [2:0]       v,
  input  logic             incr,
  input  logic             decr,
  input  logic             jizr,
  input  logic             jnzr,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] off;

  always_comb begin
    off = (v != 3'd0) ? WIDTH'({v, 1'b0}) : WIDTH'(JUMP_DEFAULT_OFF);
    res = x;
    if (jizr || jnzr) begin
      res = x + off;
    end else if (incr) begin
      res = x + WIDTH'(1);
    end else if (decr) begin
      res = x - WIDTH'(1);
    end
  end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Op sequencer owning the PC; one shared adder serves register updates (REG)
// and PC updates (PCU). Handshake: an op transfers on any cycle with op_valid && op_ready.
module reg_seq_ctrl
  import reg_seq_pkg::*;
#(
  parameter int              WIDTH    = DATA_W,
  parameter int              NREG     = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int             RSEL_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [RSEL_W-1:0] op_rsel,
  input  logic [2:0]        op_v,
  input  logic              stall,
  output logic [RSEL_W-1:0] reg_raddr,
  input  logic [WIDTH-1:0]  reg_rdata,
  output logic              reg_we,
  output logic [RSEL_W-1:0] reg_waddr,
  output logic [WIDTH-1:0]  reg_wdata,
  output logic [WIDTH-1:0]  pc,
  output logic              done,
  output logic              res_zero,
  output state_e            dbg_state
);

  state_e            state;
  op_e               op_q;
  op_e               op_in;
  logic [RSEL_W-1:0] rsel_q;
  logic [2:0]        v_q;
  logic [WIDTH-1:0]  pc_q;
  logic              res_zero_q;

  logic              accept;
  logic              in_reg;
  logic              in_pcu;
  logic              taken;

  logic [WIDTH-1:0]  ax;
  logic              a_incr;
  logic              a_decr;
  logic              a_jizr;
  logic              a_jnzr;
  logic [WIDTH-1:0]  ares;

  assign op_in    = op_decode(op_code);
  assign in_reg   = (state == S_REG);
  assign in_pcu   = (state == S_PCU);
  assign op_ready = (state == S_IDLE || state == S_PCU) && !stall;
  assign accept   = op_valid && op_ready;

  assign reg_raddr = rsel_q;
  assign reg_waddr = rsel_q;
  assign reg_wdata = ares;
  // Gated by reset so an op aborted in REG never reaches the register file.
  assign reg_we    = in_reg && !stall && !reset;
  assign done      = in_pcu && !stall && !reset;
  assign pc        = pc_q;
  assign res_zero  = res_zero_q;
  assign dbg_state = state;

  assign taken = ((op_q == OP_JIZR) && (reg_rdata == '0)) ||
                 ((op_q == OP_JNZR) && (reg_rdata != '0));

  // Operand mux: REG feeds the register value, PCU feeds the PC.
  always_comb begin
    ax     = pc_q;
    a_incr = 1'b0;
    a_decr = 1'b0;
    a_jizr = 1'b0;
    a_jnzr = 1'b0;
    if (in_reg) begin
      ax     = reg_rdata;
      a_incr = (op_q == OP_INCR);
      a_decr = (op_q == OP_DECR);
    end else if (in_pcu) begin
      if (taken) begin
        a_jizr = (op_q == OP_JIZR);
        a_jnzr = (op_q == OP_JNZR);
      end else begin
        a_incr = 1'b1;
      end
    end
  end

  reg_arithmetic #(.WIDTH(WIDTH)) u_arith (
    .x    (ax),
    .v    (v_q),
    .incr (a_incr),
    .decr (a_decr),
    .jizr (a_jizr),
    .jnzr (a_jnzr),
    .res  (ares)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      rsel_q     <= '0;
      v_q        <= '0;
      pc_q       <= RESET_PC;
      res_zero_q <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        op_q   <= op_in;
        rsel_q <= op_rsel;
        v_q    <= op_v;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= op_needs_reg(op_in) ? S_REG : S_PCU;
          end
        end
        S_REG: begin
          res_zero_q <= (ares == '0);
          state      <= S_PCU;
        end
        S_PCU: begin
          pc_q <= ares;
          if (accept) begin
            state <= op_needs_reg(op_in) ? S_REG : S_PCU;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: directed ops with hand-computed results, a register
// file model, and a monitor that checks retirements and writes from queues.
module tb_reg_seq_ctrl;
  import reg_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [2:0] op_rsel;
  logic [2:0] op_v;
  logic       stall;
  logic [2:0] reg_raddr;
  logic [9:0] reg_rdata;
  logic       reg_we;
  logic [2:0] reg_waddr;
  logic [9:0] reg_wdata;
  logic [9:0] pc;
  logic       done;
  logic       res_zero;
  state_e     dbg_state;

  logic [9:0] rf[8];
  logic       pre_we;
  logic [2:0] pre_addr;
  logic [9:0] pre_data;

  // done entry: [11] check res_zero, [10] res_zero, [9:0] pc after retire
  logic [11:0] exp_done_q[$];
  // write entry: [12:10] address, [9:0] data
  logic [12:0] exp_wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic       pc_pend = 1'b0;
  logic [9:0] pc_pend_exp;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  reg_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_rsel   (op_rsel),
    .op_v      (op_v),
    .stall     (stall),
    .reg_raddr (reg_raddr),
    .reg_rdata (reg_rdata),
    .reg_we    (reg_we),
    .reg_waddr (reg_waddr),
    .reg_wdata (reg_wdata),
    .pc        (pc),
    .done      (done),
    .res_zero  (res_zero),
    .dbg_state (dbg_state)
  );

  assign reg_rdata = rf[reg_raddr];

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (reg_we) rf[reg_waddr] <= reg_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [11:0] de;
    logic [12:0] we;
    if (reset) begin
      pc_pend = 1'b0;
    end else begin
      if (pc_pend) begin
        check("pc_after_done", pc, pc_pend_exp);
        pc_pend = 1'b0;
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          de = exp_done_q.pop_front();
          if (de[11]) check("res_zero", res_zero, de[10]);
          pc_pend     = 1'b1;
          pc_pend_exp = de[9:0];
        end
      end
      if (reg_we) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          we = exp_wr_q.pop_front();
          check("write_addr", reg_waddr, we[12:10]);
          check("write_data", reg_wdata, we[9:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_reg(input logic [2:0] a, input logic [9:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic wait_accept();
    int w = 0;
    @(negedge clk);
    while (!op_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic send_op(input logic [2:0] code, input logic [2:0] rs, input logic [2:0] v,
                         input logic [9:0] epc, input logic wr, input logic [9:0] ewd,
                         input logic erz, input int nstall);
    exp_done_q.push_back({wr, erz, epc});
    if (wr) exp_wr_q.push_back({rs, ewd});
    op_valid = 1'b1; op_code = code; op_rsel = rs; op_v = v;
    wait_accept();
    if (nstall > 0) begin
      stall = 1'b1;
      repeat (nstall) begin
        @(negedge clk);
        check("stall_we", reg_we, 0);
        check("stall_done", done, 0);
        check("stall_ready", op_ready, 0);
        check("stall_pc", pc, epc - 10'd1);
      end
      @(posedge clk); #1;
      stall = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (dbg_state != S_IDLE && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", dbg_state, S_IDLE);
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [9:0] pe;
    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_rsel = '0; op_v = '0;
    stall = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    @(posedge clk); #1;
    set_reg(3'd0, 10'd0);
    set_reg(3'd1, 10'd0);
    set_reg(3'd2, 10'd5);
    set_reg(3'd3, 10'd1023);
    set_reg(3'd4, 10'd0);
    set_reg(3'd5, 10'd1);
    set_reg(3'd6, 10'd0);
    set_reg(3'd7, 10'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_pc", pc, 0);
    check("reset_done", done, 0);
    check("reset_we", reg_we, 0);
    check("reset_rz", res_zero, 0);
    check("reset_ready", op_ready, 1);
    check("reset_state", dbg_state, S_IDLE);
    @(posedge clk); #1;

    // NOPs back-to-back, including an unused encoding
    send_op(3'd0, 3'd0, 3'd0, 10'd1, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd0, 3'd0, 3'd0, 10'd2, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd0, 3'd0, 3'd0, 10'd3, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd7, 3'd0, 3'd0, 10'd4, 1'b0, 10'd0, 1'b0, 0);

    // INCR r2 (5 -> 6); ready must drop for the REG cycle
    send_op(3'd1, 3'd2, 3'd0, 10'd5, 1'b1, 10'd6, 1'b0, 0);
    @(negedge clk);
    check("ready_low_in_reg", op_ready, 0);
    @(posedge clk); #1;

    send_op(3'd2, 3'd1, 3'd0, 10'd6, 1'b1, 10'd1023, 1'b0, 0);
    send_op(3'd1, 3'd3, 3'd0, 10'd7, 1'b1, 10'd0, 1'b1, 0);
    send_op(3'd0, 3'd0, 3'd0, 10'd8, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd0, 3'd0, 3'd0, 10'd9, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd0, 3'd0, 3'd0, 10'd10, 1'b0, 10'd0, 1'b0, 0);

    // jumps on r4 == 0
    send_op(3'd3, 3'd4, 3'd3, 10'd16, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd4, 3'd4, 3'd3, 10'd17, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd3, 3'd4, 3'd0, 10'd33, 1'b0, 10'd0, 1'b0, 0);

    // walk pc up to 1020 with taken jumps on r0 == 0
    pe = 10'd33;
    for (int k = 0; k < 61; k++) begin
      pe = pe + 10'd16;
      send_op(3'd3, 3'd0, 3'd0, pe, 1'b0, 10'd0, 1'b0, 0);
    end
    send_op(3'd3, 3'd0, 3'd5, 10'd1019, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd0, 3'd0, 3'd0, 10'd1020, 1'b0, 10'd0, 1'b0, 0);
    send_op(3'd3, 3'd0, 3'd0, 10'd12, 1'b0, 10'd0, 1'b0, 0);

    // DECR r5 to zero, then JNZR r5 sees the fresh write: not taken
    send_op(3'd2, 3'd5, 3'd0, 10'd13, 1'b1, 10'd0, 1'b1, 0);
    send_op(3'd4, 3'd5, 3'd2, 10'd14, 1'b0, 10'd0, 1'b0, 0);

    // INCR r2 (6 -> 7) stalled three cycles in REG
    send_op(3'd1, 3'd2, 3'd0, 10'd15, 1'b1, 10'd7, 1'b0, 3);
    wait_idle();

    // reset while an INCR sits in REG: no write, pc back to 0
    op_valid = 1'b1; op_code = 3'd1; op_rsel = 3'd2; op_v = 3'd0;
    wait_accept();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_we", reg_we, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_pc", pc, 0);
    check("rst_mid_state", dbg_state, S_IDLE);
    check("rst_mid_r2", rf[2], 10'd7);
    check("rst_mid_ready", op_ready, 1);
    @(posedge clk); #1;
    send_op(3'd0, 3'd0, 3'd0, 10'd1, 1'b0, 10'd0, 1'b0, 0);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    check("final_r3", rf[3], 10'd0);
    check("final_r1", rf[1], 10'd1023);
    check("done_q_empty", exp_done_q.size(), 0);
    check("wr_q_empty", exp_wr_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
